p2s_stream: RTL and testbench
=============================

# p2s_stream

Parametrised parallel-to-serial converter that serialises N-bit words into W-bit beats over valid/ready handshakes on both sides. It has a one-word holding register, so back-to-back words stream with no idle cycle between them. It supports MSB-first or LSB-first ordering and marks the final beat of each word with `s_last`. It sits between a word-wide producer and a narrow serial link or FIFO, replacing the fixed-width, single-buffered LSB-first converter.

## Interface
- `N`, default 16: parallel word width; must be a multiple of `W`.
- `W`, default 1: serial beat width. `BEATS = N/W` must be ≥ 2.
- `MSB_FIRST`, default 0: 1 sends the top `W` bits first; 0 sends bits `[W-1:0]` first.
- `clk` input, 1: clock; all state updates on the rising edge.
- `rst` input, 1: reset; asynchronous, active-high.
- `p_valid` input, 1: parallel word offered.
- `p_data` input, N: parallel word.
- `p_ready` output, 1: block accepts `p_data` this cycle.
- `s_valid` output, 1: serial beat valid.
- `s_data` output, W: serial beat.
- `s_ready` input, 1: downstream accepts the beat.
- `s_last` output, 1: current beat is the final beat of its word.

## Operation
- Handshake rules:
  - `acc = p_valid & p_ready`.
  - `fire = s_valid & s_ready`.
  - `lfire = fire & s_last`.
- State machine has two states:
  - IDLE: shifter empty, `s_valid = 0`.
  - SHIFT: shifter holds a word, `s_valid = 1`.
- Beat counter is `$clog2(BEATS)` bits (extended by 1 bit when parity is enabled). It is reset to 0 on every shifter load.
- `p_ready = !hold_valid`, decoded combinationally from a register.
- IDLE: `acc` loads `p_data` into the shifter, sets count to 0 and moves to SHIFT.
- SHIFT with `fire & !lfire`:
  - Shift by `W`: right when `MSB_FIRST = 0`, left when `MSB_FIRST = 1`.
  - count + 1.
- SHIFT with `lfire`, priority order:
  - If `hold_valid`: load the holding register into the shifter and clear `hold_valid`.
  - Else if `acc`: load `p_data` into the shifter directly.
  - Else: go to IDLE.
- SHIFT with `acc` and no `lfire`: `p_data` goes into the holding register and `hold_valid` is set.
- `acc` and `lfire` in the same cycle while the holding register is empty: the word bypasses the holding register and `hold_valid` stays 0.
- Beat order:
  - `s_data` comes from the shifter's low `W` bits when `MSB_FIRST = 0`, and from its high `W` bits when `MSB_FIRST = 1`.
  - Beat k is `p_data[k*W +: W]` (LSB-first) or `p_data[N-1-k*W -: W]` (MSB-first).
- `s_last = (count == BEATS-1)` while in SHIFT. With the parity feature enabled, see Configuration.
- `s_data` and `s_last` hold stable while `s_valid & !s_ready`; back-pressure never drops or reorders beats.
- `p_data` is sampled only on `acc`.

## Timing
- Reset values:
  - `s_valid = 0`, `s_data = 0`, `s_last = 0`.
  - `p_ready = 1` (hold empty), state IDLE, count 0.
- Reset asserted mid-word discards the shifter and holding-register contents immediately; no partial word is resumed.
- Latency: word accepted in cycle t (from IDLE) gives its first beat valid at t+1.
- Throughput: with `s_ready` held at 1 and a word always available, `s_valid` stays at 1 continuously. One word every `BEATS` cycles (`BEATS+1` with parity).
- `p_ready` falls the cycle after the holding register fills. It rises the cycle after the `lfire` that drains it.

## Configuration
- Macro: `P2S_PARITY_EN`.
- When defined:
  - On every shifter load, the even parity `^word` is stored.
  - After the last data beat, one extra beat is sent with `s_data = {W-1 zeros, parity}`.
  - `s_last` is asserted on the parity beat, not on data beat `BEATS-1`.
  - Each word takes `BEATS+1` beats.
- When undefined: no parity logic is built and each word is exactly `BEATS` beats, with `s_last` on beat `BEATS-1`.

## Test plan
- N=16, W=4, MSB_FIRST=1, `s_ready = 1`, send `16'hA5C3` → beats `A, 5, C, 3` on consecutive cycles starting the cycle after `acc`. `s_last = 1` only on `3`, then `s_valid = 0`.
- N=8, W=1, MSB_FIRST=0, send `8'b1011_0010` → bits `0,1,0,0,1,1,0,1`. `s_last` on the 8th beat.
- N=16, W=4, three words `1234`, `5678`, `9ABC` offered with `p_valid` held at 1 and `s_ready = 1` → 12 consecutive valid beats with no gap, `p_ready` low while the holding register is full, `s_last` every 4th beat.
- Back-pressure: `s_ready` toggled 1,0,0,1,... during `16'hA5C3` → `s_data` constant on stalled cycles, exactly 4 beats delivered in order.
- Assert `rst` after the 2nd beat of `A5C3` with a second word held → `s_valid = 0`, `p_ready = 1` immediately. A new word `0F0F` sent after reset → beats `0,F,0,F` only.
- With `P2S_PARITY_EN`, N=8, W=4, send `8'h07` → beats `0`, `7`, `4'b0001` (parity 1). `s_last` only on the third beat.

Source files
------------

// File: rtl/p2s_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : p2s_stream_if
// Purpose  : Parallel-word input and serial-beat output handshake bundle
//            used by p2s_stream.
// Revision : 1.0 - initial release
// ============================================================================
interface p2s_stream_if #(
    parameter int N = 16,
    parameter int W = 1
);
    logic         p_valid;
    logic [N-1:0] p_data;
    logic         p_ready;
    logic         s_valid;
    logic [W-1:0] s_data;
    logic         s_ready;
    logic         s_last;

    // Environment side: word producer plus serial consumer.
    modport master (
        output p_valid, p_data, s_ready,
        input  p_ready, s_valid, s_data, s_last
    );

    // Converter side.
    modport slave (
        input  p_valid, p_data, s_ready,
        output p_ready, s_valid, s_data, s_last
    );
endinterface
`default_nettype wire

// File: rtl/p2s_stream.sv
`default_nettype none
// ============================================================================
// Module   : p2s_stream
// Purpose  : N-bit word to W-bit beat serialiser with one-word holding
//            register. Optional trailing even-parity beat: P2S_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module p2s_stream #(
    parameter int N         = 16,
    parameter int W         = 1,
    parameter int MSB_FIRST = 0
) (
    input  wire logic   clk,
    input  wire logic   rst,
    p2s_stream_if.slave bus
);
    localparam int c_BEATS = N / W;
`ifdef P2S_PARITY_EN
    localparam int c_CW    = $clog2(c_BEATS) + 1;
    localparam int c_LAST  = c_BEATS;
`else
    localparam int c_CW    = $clog2(c_BEATS);
    localparam int c_LAST  = c_BEATS - 1;
`endif
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(c_LAST);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [N-1:0]    r_shift, w_shift_nxt;
    logic [N-1:0]    r_hold, w_hold_nxt;
    logic            r_hold_valid, w_hold_valid_nxt;
    logic [c_CW-1:0] r_cnt, w_cnt_nxt;
    logic            w_load;
    logic [N-1:0]    w_load_data;
    logic [N-1:0]    w_shifted;
    logic [W-1:0]    w_beat;
    logic            w_s_valid, w_s_last, w_acc, w_fire, w_lfire;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_beat    = r_shift[N-1 -: W];
            assign w_shifted = r_shift << W;
        end else begin : g_lsb_first
            assign w_beat    = r_shift[W-1:0];
            assign w_shifted = r_shift >> W;
        end
    endgenerate

    assign w_s_valid   = (r_state == ST_SHIFT);
    assign w_s_last    = w_s_valid && (r_cnt == c_CNT_LAST);
    assign w_acc       = bus.p_valid && !r_hold_valid;
    assign w_fire      = w_s_valid && bus.s_ready;
    assign w_lfire     = w_fire && w_s_last;

    assign bus.p_ready = !r_hold_valid;
    assign bus.s_valid = w_s_valid;
    assign bus.s_last  = w_s_last;

`ifdef P2S_PARITY_EN
    logic r_par;

    // The parity beat follows the data beats; the counter only reaches
    // c_CNT_LAST on that extra beat.
    assign bus.s_data = (r_cnt == c_CNT_LAST) ? W'(r_par) : w_beat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (w_load) begin
            r_par <= ^w_load_data;
        end
    end
`else
    assign bus.s_data = w_beat;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_cnt_nxt        = r_cnt;
        w_hold_nxt       = r_hold;
        w_hold_valid_nxt = r_hold_valid;
        w_load           = 1'b0;
        w_load_data      = bus.p_data;
        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_lfire) begin
                    // A held word takes precedence; otherwise an incoming
                    // word bypasses the holding register.
                    if (r_hold_valid) begin
                        w_load           = 1'b1;
                        w_load_data      = r_hold;
                        w_hold_valid_nxt = 1'b0;
                    end else if (w_acc) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    if (w_fire) begin
                        w_shift_nxt = w_shifted;
                        w_cnt_nxt   = r_cnt + c_CNT_ONE;
                    end
                    if (w_acc) begin
                        w_hold_nxt       = bus.p_data;
                        w_hold_valid_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_load) begin
            w_shift_nxt = w_load_data;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_cnt        <= w_cnt_nxt;
            r_hold       <= w_hold_nxt;
            r_hold_valid <= w_hold_valid_nxt;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_p2s_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_p2s_stream
// Purpose  : Directed self-checking bench for p2s_stream in three widths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_p2s_stream;
`ifdef P2S_PARITY_EN
    localparam int c_PAR = 1;
`else
    localparam int c_PAR = 0;
`endif
    localparam int c_BPW_A = 4 + c_PAR;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    p2s_stream_if #(.N(16), .W(4)) ifa ();
    p2s_stream_if #(.N(8),  .W(1)) ifb ();
    p2s_stream_if #(.N(8),  .W(4)) ifc ();

    p2s_stream #(.N(16), .W(4), .MSB_FIRST(1)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    p2s_stream #(.N(8),  .W(1), .MSB_FIRST(0)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
    p2s_stream #(.N(8),  .W(4), .MSB_FIRST(1)) u_dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Beat k of a 16-bit word sent MSB-first in nibbles, then the parity beat.
    function automatic logic [3:0] beat_a(input logic [15:0] w, input int k);
        if (k < 4) return w[15-4*k -: 4];
        return {3'b000, ^w};
    endfunction

    task automatic recv_a(input string tag, input logic [15:0] w);
        for (int k = 0; k < c_BPW_A; k++) begin
            chk({tag, "_valid"}, ifa.s_valid, 1);
            chk({tag, "_data"},  ifa.s_data, beat_a(w, k));
            chk({tag, "_last"},  ifa.s_last, (k == c_BPW_A - 1));
            @(negedge clk);
        end
        chk({tag, "_idle"}, ifa.s_valid, 0);
    endtask

    logic [15:0] words [3] = '{16'h1234, 16'h5678, 16'h9ABC};
    logic        exp_b [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0]  exp_c [3] = '{4'h0, 4'h7, 4'h1};
    logic [3:0]  pat = 4'b1001;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  idx;
        int  k;
        int  cyc;
        logic acc;

        ifa.p_valid = 1'b0; ifa.p_data = '0; ifa.s_ready = 1'b0;
        ifb.p_valid = 1'b0; ifb.p_data = '0; ifb.s_ready = 1'b0;
        ifc.p_valid = 1'b0; ifc.p_data = '0; ifc.s_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_a_valid", ifa.s_valid, 0);
        chk("rst_a_data",  ifa.s_data,  0);
        chk("rst_a_last",  ifa.s_last,  0);
        chk("rst_a_pready", ifa.p_ready, 1);
        chk("rst_b_valid", ifb.s_valid, 0);
        chk("rst_b_pready", ifb.p_ready, 1);
        chk("rst_c_valid", ifc.s_valid, 0);
        chk("rst_c_pready", ifc.p_ready, 1);
        rst = 1'b0;

        // Single word, MSB-first nibbles
        @(negedge clk);
        ifa.s_ready = 1'b1;
        ifa.p_valid = 1'b1; ifa.p_data = 16'hA5C3;
        chk("t1_pready", ifa.p_ready, 1);
        @(negedge clk);
        ifa.p_valid = 1'b0;
        recv_a("t1", 16'hA5C3);

        // Single bit-serial word, LSB-first
        ifb.s_ready = 1'b1;
        ifb.p_valid = 1'b1; ifb.p_data = 8'b1011_0010;
        @(negedge clk);
        ifb.p_valid = 1'b0;
        for (int b = 0; b < 8 + c_PAR; b++) begin
            chk("t2_valid", ifb.s_valid, 1);
            chk("t2_data",  ifb.s_data, exp_b[b]);
            chk("t2_last",  ifb.s_last, (b == 7 + c_PAR));
            @(negedge clk);
        end
        chk("t2_idle", ifb.s_valid, 0);

        // Three back-to-back words, no bubbles
        idx = 0;
        ifa.p_valid = 1'b1; ifa.p_data = words[0];
        for (int c = 0; c <= 3 * c_BPW_A; c++) begin
            if (c > 0) begin
                chk("t3_valid", ifa.s_valid, 1);
                chk("t3_data",  ifa.s_data, beat_a(words[(c-1)/c_BPW_A], (c-1) % c_BPW_A));
                chk("t3_last",  ifa.s_last, ((c-1) % c_BPW_A == c_BPW_A - 1));
            end
            chk("t3_pready", ifa.p_ready,
                ((c >= 2 && c <= c_BPW_A) || (c >= c_BPW_A + 2 && c <= 2 * c_BPW_A)) ? 0 : 1);
            acc = ifa.p_valid & ifa.p_ready;
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 3) ifa.p_data = words[idx];
                else         ifa.p_valid = 1'b0;
            end
        end
        chk("t3_idle", ifa.s_valid, 0);

        // Back-pressure with s_ready pattern 1,0,0,1
        ifa.p_valid = 1'b1; ifa.p_data = 16'hA5C3;
        @(negedge clk);
        ifa.p_valid = 1'b0;
        k = 0;
        cyc = 0;
        while (k < c_BPW_A && cyc < 40) begin
            chk("t4_valid", ifa.s_valid, 1);
            chk("t4_data",  ifa.s_data, beat_a(16'hA5C3, k));
            chk("t4_last",  ifa.s_last, (k == c_BPW_A - 1));
            ifa.s_ready = pat[cyc % 4];
            if (ifa.s_ready) k++;
            cyc++;
            @(negedge clk);
        end
        chk("t4_beats", k, c_BPW_A);
        chk("t4_idle", ifa.s_valid, 0);

        // Reset mid-word with a second word held
        ifa.s_ready = 1'b1;
        ifa.p_valid = 1'b1; ifa.p_data = 16'hA5C3;
        @(negedge clk);
        ifa.p_data = 16'h1111;
        chk("t5_beat0", ifa.s_data, 4'hA);
        @(negedge clk);
        ifa.p_valid = 1'b0;
        chk("t5_beat1", ifa.s_data, 4'h5);
        chk("t5_full",  ifa.p_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid",  ifa.s_valid, 0);
        chk("t5_rst_pready", ifa.p_ready, 1);
        chk("t5_rst_last",   ifa.s_last,  0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ifa.p_valid = 1'b1; ifa.p_data = 16'h0F0F;
        @(negedge clk);
        ifa.p_valid = 1'b0;
        recv_a("t5", 16'h0F0F);

        // 8-bit word in two nibbles (plus parity beat when enabled)
        ifc.s_ready = 1'b1;
        ifc.p_valid = 1'b1; ifc.p_data = 8'h07;
        @(negedge clk);
        ifc.p_valid = 1'b0;
        for (int b = 0; b < 2 + c_PAR; b++) begin
            chk("t6_valid", ifc.s_valid, 1);
            chk("t6_data",  ifc.s_data, exp_c[b]);
            chk("t6_last",  ifc.s_last, (b == 1 + c_PAR));
            @(negedge clk);
        end
        chk("t6_idle", ifc.s_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
